mul_acc_8bit: RTL and testbench
===============================

# mul_acc_8bit

Accumulator stage directly downstream of the 8-bit pipelined multiplier. It consumes the multiplier's product/valid stream, sums a fixed-length block of consecutive valid products, and presents each block sum on a single-entry valid/ready output register. The multiplier has no backpressure, so this stage never stalls its input. When a completed sum cannot be delivered, the stage drops it and records the loss.

## Interface
- SIZE, 8, operand width of upstream multiplier; product width is 2*SIZE
- ACC_LEN, 4, products per block (2..256)
- ACC_W, 16, accumulator/result width (2*SIZE..32); lossless only if ACC_W >= 2*SIZE + clog2(ACC_LEN)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of block, output register and error flag
- prod_vld  in  1  product valid (driven by multiplier mul_en_out)
- prod  in  2*SIZE  product value (multiplier mul_out, zero-extended)
- acc_out  out  ACC_W  block sum
- acc_sat  out  1  block sum was clamped (always 0 without MUL_ACC_SAT_EN)
- acc_vld  out  1  acc_out/acc_sat valid
- acc_rdy  in  1  downstream accepts when acc_vld & acc_rdy
- blk_cnt  out  clog2(ACC_LEN)  products accumulated in current block
- drop_err  out  1  sticky: a completed block sum was discarded

## Operation
- Accumulator `acc` (ACC_W) and counter `blk_cnt`. Gaps in prod_vld are allowed and do not reset the block.
- prod_vld with blk_cnt < ACC_LEN-1: acc <= acc + prod, blk_cnt++.
- prod_vld with blk_cnt == ACC_LEN-1 (block end): sum = acc + prod goes to the output register, acc <= 0, blk_cnt <= 0.
- Output register FSM has two states, OUT_EMPTY and OUT_FULL. acc_vld = (state == OUT_FULL).
  - OUT_EMPTY, block end -> OUT_FULL; load sum and sat flag.
  - OUT_FULL, acc_rdy and no block end -> OUT_EMPTY.
  - OUT_FULL, acc_rdy and block end in the same cycle -> stay OUT_FULL; load the new sum. No drop.
  - OUT_FULL, !acc_rdy and block end -> stay OUT_FULL; the old value is held, the new sum is discarded, and drop_err <= 1.
- acc_out and acc_sat are stable while acc_vld & !acc_rdy.
- clr has priority over everything: acc, blk_cnt, acc_sat, drop_err <= 0; state <= OUT_EMPTY. A product arriving in the clr cycle is discarded.
- Arithmetic is unsigned. prod is zero-extended to ACC_W before the add.
- Saturation and sat flag: see Configuration.

## Timing
- Reset values: acc_out = 0, acc_sat = 0, acc_vld = 0, blk_cnt = 0, drop_err = 0; internal acc = 0.
- Latency: acc_vld rises on the clock edge that samples the final product, i.e. it is visible the cycle after the final prod_vld.
- Throughput: one product per cycle, sustained. With acc_rdy held high, back-to-back blocks never drop.
- Reset asserted mid-block discards the partial sum and any pending output.
- A clr pulse of any length gives the same state as reset after its last cycle.

## Configuration
- MUL_ACC_SAT_EN defined: each add clamps to 2^ACC_W - 1 on overflow. A clamp anywhere in the block sets the block's sat flag, which is reported on acc_sat with the result.
- MUL_ACC_SAT_EN undefined: adds wrap modulo 2^ACC_W and acc_sat is tied to 0.

## Structure
- Package mul_acc_pkg holds:
  - the out_state_t enum (OUT_EMPTY, OUT_FULL)
  - the constant/function for counter width, clog2(ACC_LEN)
- One natural sub-module, mul_acc_sat_add. It is the ACC_W adder taking a (2*SIZE) operand. Its outputs are the sum and an overflow flag. Saturation inside it sits behind MUL_ACC_SAT_EN.

## Test plan
All scenarios use ACC_LEN = 4 and ACC_W = 16.
- Basic block: products 100, 200, 300, 400 on consecutive cycles, acc_rdy = 1 -> acc_out = 1000 and acc_vld = 1 the cycle after 400; acc_vld = 0 the following cycle.
- Overflow: 4 x 65025. With MUL_ACC_SAT_EN -> acc_out = 65535, acc_sat = 1. Without -> acc_out = 63492, acc_sat = 0.
- Backpressure: acc_rdy = 0 through two blocks (sums 10, then 20) -> acc_out holds 10, drop_err = 1. Then acc_rdy = 1 -> 10 is accepted, acc_vld drops, drop_err stays 1 until clr.
- Simultaneous accept and load: acc_rdy = 1 on the same cycle as block-end of the second block -> acc_vld stays 1, acc_out changes from the first sum to the second, drop_err = 0.
- Gaps and clear: products 5, idle, 7, clr, then 1, 1, 1, 1 -> blk_cnt = 2 before clr and 0 after; result is 4, not 16.
- Async reset mid-block: blk_cnt = 3, drop rst_n between edges -> all outputs 0 immediately; the next full block sums correctly.

Source files
------------

// File: rtl/mul_acc_pkg.sv
// rtl/mul_acc_pkg.sv - shared types and sizing helpers for the product accumulator
package mul_acc_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/mul_acc_sat_add.sv
// rtl/mul_acc_sat_add.sv - accumulator adder with carry-out; clamps on overflow when MUL_ACC_SAT_EN is defined
module mul_acc_sat_add #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic [ACC_W:0] w_wide;

    assign w_wide = {1'b0, i_acc} + (ACC_W+1)'(i_prod);
    assign o_ovf  = w_wide[ACC_W];

`ifdef MUL_ACC_SAT_EN
    assign o_sum = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
`else
    assign o_sum = w_wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/mul_acc_8bit.sv
// rtl/mul_acc_8bit.sv - block accumulator after the 8-bit multiplier; MUL_ACC_SAT_EN enables saturating adds
module mul_acc_8bit
    import mul_acc_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int ACC_LEN = 4,
    parameter int ACC_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          prod_vld,
    input  logic [2*SIZE-1:0]             prod,
    output logic [ACC_W-1:0]              acc_out,
    output logic                          acc_sat,
    output logic                          acc_vld,
    input  logic                          acc_rdy,
    output logic [cnt_width(ACC_LEN)-1:0] blk_cnt,
    output logic                          drop_err
);

    localparam int                PROD_W   = 2 * SIZE;
    localparam int                CNT_W    = cnt_width(ACC_LEN);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ACC_LEN - 1);

`ifdef MUL_ACC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_blk_cnt;
    logic             r_blk_sat;
    logic [ACC_W-1:0] r_acc_out;
    logic             r_acc_sat;
    logic             r_drop_err;
    out_state_t       r_state;

    out_state_t       w_state_nxt;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;
    logic             w_sat_nxt;
    logic             w_blk_end;
    logic             w_load;
    logic             w_drop;

    mul_acc_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .i_acc  (r_acc),
        .i_prod (prod),
        .o_sum  (w_sum),
        .o_ovf  (w_ovf)
    );

    assign w_blk_end = prod_vld & (r_blk_cnt == LAST_CNT);
    // Sat flag is sticky across the block and forced low when clamping is not built in.
    assign w_sat_nxt = SAT_EN & (r_blk_sat | w_ovf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_blk_cnt <= '0;
            r_blk_sat <= 1'b0;
        end else if (clr || w_blk_end) begin
            r_acc     <= '0;
            r_blk_cnt <= '0;
            r_blk_sat <= 1'b0;
        end else if (prod_vld) begin
            r_acc     <= w_sum;
            r_blk_cnt <= r_blk_cnt + CNT_W'(1);
            r_blk_sat <= w_sat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OUT_EMPTY;
        end else if (clr) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            OUT_EMPTY: if (w_blk_end) w_state_nxt = OUT_FULL;
            OUT_FULL:  if (acc_rdy && !w_blk_end) w_state_nxt = OUT_EMPTY;
            default:   w_state_nxt = OUT_EMPTY;
        endcase
    end

    // A block end while full is only lost if the held value is not leaving this cycle.
    always_comb begin
        w_load  = 1'b0;
        w_drop  = 1'b0;
        acc_vld = 1'b0;
        unique case (r_state)
            OUT_EMPTY: w_load = w_blk_end;
            OUT_FULL: begin
                acc_vld = 1'b1;
                w_load  = w_blk_end & acc_rdy;
                w_drop  = w_blk_end & ~acc_rdy;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_out <= '0;
            r_acc_sat <= 1'b0;
        end else if (clr) begin
            r_acc_out <= '0;
            r_acc_sat <= 1'b0;
        end else if (w_load) begin
            r_acc_out <= w_sum;
            r_acc_sat <= w_sat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_err <= 1'b0;
        end else if (clr) begin
            r_drop_err <= 1'b0;
        end else if (w_drop) begin
            r_drop_err <= 1'b1;
        end
    end

    assign acc_out  = r_acc_out;
    assign acc_sat  = r_acc_sat;
    assign blk_cnt  = r_blk_cnt;
    assign drop_err = r_drop_err;

endmodule

// File: tb/tb_mul_acc_8bit.sv
// tb/tb_mul_acc_8bit.sv - scoreboard bench for mul_acc_8bit (ACC_LEN 4, ACC_W 16); honours MUL_ACC_SAT_EN
module tb_mul_acc_8bit;

    localparam int ACC_LEN = 4;
    localparam int ACC_W   = 16;
    localparam int MAXV    = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        prod_vld = 1'b0;
    logic [15:0] prod = '0;
    logic [15:0] acc_out;
    logic        acc_sat;
    logic        acc_vld;
    logic        acc_rdy = 1'b0;
    logic [1:0]  blk_cnt;
    logic        drop_err;

    typedef struct {
        int s;
        bit sat;
    } exp_t;

    exp_t q[$];
    int   m_acc, m_cnt;
    bit   m_full, m_drop, m_bsat;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mul_acc_8bit #(.SIZE(8), .ACC_LEN(ACC_LEN), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .prod_vld (prod_vld),
        .prod     (prod),
        .acc_out  (acc_out),
        .acc_sat  (acc_sat),
        .acc_vld  (acc_vld),
        .acc_rdy  (acc_rdy),
        .blk_cnt  (blk_cnt),
        .drop_err (drop_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_acc = 0; m_cnt = 0; m_full = 0; m_drop = 0; m_bsat = 0;
        q.delete();
    endtask

    task automatic m_add(input int p, output int s, output bit ovf);
        int w;
        w = m_acc + p;
`ifdef MUL_ACC_SAT_EN
        if (w > MAXV) begin s = MAXV; ovf = 1; end
        else begin s = w; ovf = 0; end
`else
        s = w & MAXV;
        ovf = 0;
`endif
    endtask

    // One cycle: drive at the falling edge, check registered outputs, advance the model, clock.
    task automatic cycle(input bit c, input bit v, input int p, input bit r);
        int s;
        bit ovf;
        exp_t e;
        clr = c; prod_vld = v; prod = p[15:0]; acc_rdy = r;
        #1;
        chk("acc_vld", acc_vld, m_full);
        chk("blk_cnt", blk_cnt, m_cnt);
        chk("drop_err", drop_err, m_drop);
        if (m_full && q.size() > 0) begin
            chk("acc_out", acc_out, q[0].s);
            chk("acc_sat", acc_sat, q[0].sat);
        end
        if (c) begin
            m_reset();
        end else if (v && m_cnt == ACC_LEN - 1) begin
            m_add(p, s, ovf);
            e.s = s;
            e.sat = m_bsat | ovf;
            if (m_full && !r) begin
                m_drop = 1;
            end else begin
                if (m_full) void'(q.pop_front());
                q.push_back(e);
                m_full = 1;
            end
            m_acc = 0; m_cnt = 0; m_bsat = 0;
        end else begin
            if (m_full && r) begin
                void'(q.pop_front());
                m_full = 0;
            end
            if (v) begin
                m_add(p, s, ovf);
                m_acc = s;
                m_bsat = m_bsat | ovf;
                m_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        #1;
        chk("rst_acc_out", acc_out, 0);
        chk("rst_acc_sat", acc_sat, 0);
        chk("rst_acc_vld", acc_vld, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_drop_err", drop_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic block
        cycle(0, 1, 100, 1); cycle(0, 1, 200, 1); cycle(0, 1, 300, 1); cycle(0, 1, 400, 1);
        chk("basic_vld", acc_vld, 1);
        chk("basic_sum", acc_out, 1000);
        cycle(0, 0, 0, 1);
        chk("basic_vld_low", acc_vld, 0);

        // overflow
        for (int i = 0; i < 4; i++) cycle(0, 1, 65025, 1);
`ifdef MUL_ACC_SAT_EN
        chk("ovf_sum", acc_out, 65535);
        chk("ovf_sat", acc_sat, 1);
`else
        chk("ovf_sum", acc_out, 63492);
        chk("ovf_sat", acc_sat, 0);
`endif
        cycle(0, 0, 0, 1);

        // backpressure with a dropped block
        cycle(0, 1, 1, 0); cycle(0, 1, 2, 0); cycle(0, 1, 3, 0); cycle(0, 1, 4, 0);
        cycle(0, 1, 2, 0); cycle(0, 1, 4, 0); cycle(0, 1, 6, 0); cycle(0, 1, 8, 0);
        chk("bp_hold", acc_out, 10);
        chk("bp_drop", drop_err, 1);
        cycle(0, 0, 0, 1);
        chk("bp_vld_low", acc_vld, 0);
        chk("bp_drop_sticky", drop_err, 1);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("bp_drop_clr", drop_err, 0);

        // simultaneous accept and load
        cycle(0, 1, 3, 0); cycle(0, 1, 3, 0); cycle(0, 1, 3, 0); cycle(0, 1, 3, 0);
        cycle(0, 1, 5, 0); cycle(0, 1, 5, 0); cycle(0, 1, 5, 0);
        chk("sim_first", acc_out, 12);
        cycle(0, 1, 5, 1);
        chk("sim_vld", acc_vld, 1);
        chk("sim_second", acc_out, 20);
        chk("sim_nodrop", drop_err, 0);
        cycle(0, 0, 0, 1);

        // gaps and clear, product in clr cycle discarded
        cycle(0, 1, 5, 1); cycle(0, 0, 0, 1); cycle(0, 1, 7, 1);
        chk("gap_cnt", blk_cnt, 2);
        cycle(1, 1, 99, 1);
        chk("clr_cnt", blk_cnt, 0);
        cycle(0, 1, 1, 1); cycle(0, 1, 1, 1); cycle(0, 1, 1, 1); cycle(0, 1, 1, 1);
        chk("clr_sum", acc_out, 4);
        cycle(0, 0, 0, 1);

        // back-to-back blocks under sustained ready
        for (int i = 0; i < 12; i++) cycle(0, 1, $urandom_range(0, 65025), 1);
        chk("b2b_nodrop", drop_err, 0);
        cycle(0, 0, 0, 1);

        // async reset mid-block with an output pending
        cycle(0, 1, 9, 0); cycle(0, 1, 9, 0); cycle(0, 1, 9, 0); cycle(0, 1, 9, 0);
        cycle(0, 1, 1, 0); cycle(0, 1, 1, 0); cycle(0, 1, 1, 0);
        chk("ar_cnt", blk_cnt, 3);
        clr = 0; prod_vld = 0; acc_rdy = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_acc_out", acc_out, 0);
        chk("ar_acc_vld", acc_vld, 0);
        chk("ar_blk_cnt", blk_cnt, 0);
        chk("ar_drop_err", drop_err, 0);
        chk("ar_acc_sat", acc_sat, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cycle(0, 1, 3, 1); cycle(0, 1, 3, 1); cycle(0, 1, 3, 1); cycle(0, 1, 3, 1);
        chk("ar_sum", acc_out, 12);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
